// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: memory handshake bus between the multicycle controller and shared memory
//   mem_req    controller -> memory  access request
//   mem_we     controller -> memory  write enable (sw)
//   iord       controller -> memory  address select: 0=PC, 1=ALUOut
//   mem_ready  memory -> controller  access complete
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, mem_we, iord, input mem_ready);
    modport slave  (input mem_req, mem_we, iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a shared-memory multicycle MIPS datapath
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (master)          mem_req, mem_we, iord out; mem_ready in
//   opcode, zero          IR opcode field, ALU zero flag
//   ir_write, pc_write    IR / PC load strobes; pc_src selects the PC source
//   alusrc_a, alusrc_b    ALU operand selects; aluop selects the ALU function
//   regdst, memtoreg      register write destination / data selects; regwrite strobe
//   illegal, mem_err      one-cycle pulses: unknown opcode, memory timeout
//   state                 FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//   MULTICYCLE_CTRL_PERF_EN adds perf_cycles / perf_instr counters
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus,
    input  logic [5:0]        opcode,
    input  logic              zero,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              alusrc_a,
    output logic [1:0]        alusrc_b,
    output logic [1:0]        aluop,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              illegal,
    output logic              mem_err,
    output logic [2:0]        state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_instr
`endif
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [2:0]        nxt;
    logic [5:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_req, mem_we, iord;
    logic              waiting, tmo, legal;

    assign bus.mem_req = mem_req;
    assign bus.mem_we  = mem_we;
    assign bus.iord    = iord;

    assign waiting = (state == FETCH || state == MEM) && !bus.mem_ready;
    assign tmo     = waiting && wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1);
    assign legal   = opcode inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_BEQ, OP_BNE, OP_J};

    always_comb begin
        nxt = state;
        {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc_a, alusrc_b, aluop} = '0;
        {regdst, memtoreg, regwrite, illegal, mem_err} = '0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                alusrc_b = 2'b01;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end else if (tmo) begin
                    mem_err = 1'b1;
                end
            end
            // Decode reads the live opcode; op_q only becomes valid from EXEC on.
            DECODE: begin
                alusrc_b = 2'b11;
                if (opcode == OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    nxt      = FETCH;
                end else if (legal) begin
                    nxt = EXEC;
                end else begin
                    illegal = 1'b1;
                    nxt     = FETCH;
                end
            end
            EXEC: begin
                alusrc_a = 1'b1;
                if (op_q == OP_BEQ || op_q == OP_BNE) begin
                    aluop    = 2'b01;
                    pc_src   = 2'b01;
                    pc_write = (op_q == OP_BEQ) ? zero : !zero;
                    nxt      = FETCH;
                end else begin
                    alusrc_b = (op_q == OP_R) ? 2'b00 : 2'b10;
                    aluop    = (op_q == OP_R) ? 2'b10 : (op_q == OP_ANDI) ? 2'b11 : 2'b00;
                    nxt      = (op_q == OP_LW || op_q == OP_SW) ? MEM : WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = op_q == OP_SW;
                if (bus.mem_ready) begin
                    nxt = (op_q == OP_LW) ? WB : FETCH;
                end else if (tmo) begin
                    mem_err = 1'b1;
                    nxt     = FETCH;
                end
            end
            WB: begin
                regwrite = 1'b1;
                regdst   = op_q == OP_R;
                memtoreg = op_q == OP_LW;
                nxt      = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // Outputs are forced quiet while reset is held, independent of the clock.
        if (!rst_n) begin
            {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc_a, alusrc_b, aluop} = '0;
            {regdst, memtoreg, regwrite, illegal, mem_err} = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE)
                op_q <= opcode;
            // Leaving FETCH/MEM (ready or timeout) clears the counter, so every entry starts at 0.
            wait_cnt <= (waiting && !tmo) ? wait_cnt + 1'b1 : '0;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic done;

    // Every return to FETCH from a later state retires an instruction unless it was aborted.
    assign done = state != FETCH && nxt == FETCH && !illegal && !mem_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_instr  <= '0;
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
            if (done)
                perf_instr <= perf_instr + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level expectation queue checked against the controller every cycle
module tb_multicycle_ctrl;
    localparam int MAX = 15;
    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] J    = 6'b000010;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, iord, irw, pcw;
        logic [1:0] pcs;
        logic       a;
        logic [1:0] b, op;
        logic       rd, m2r, rw, ill, err;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] opc;
        logic       z;
        logic       rdy;
        out_t       e;
        string      tag;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       zero = 1'b0;
    logic [5:0] opcode = '0;
    logic       ir_write, pc_write, alusrc_a, regdst, memtoreg, regwrite, illegal, mem_err;
    logic [1:0] pc_src, alusrc_b, aluop;
    logic [2:0] state;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .opcode(opcode), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alusrc_a(alusrc_a),
        .alusrc_b(alusrc_b), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    cyc_t q[$];
    int   total = 0;
    int   bad = 0;

    task automatic push(input logic rst, input logic [5:0] opc, input logic z, input logic rdy,
                        input out_t e, input string tag);
        cyc_t c;
        c.rst = rst; c.opc = opc; c.z = z; c.rdy = rdy; c.e = e; c.tag = tag;
        q.push_back(c);
    endtask

    // Expected cycle sequence of one instruction: fw fetch waits, mw memory waits.
    task automatic instr(input logic [5:0] opc, input logic z, input int fw, input int mw,
                         input string nm);
        out_t e;
        logic br, ls, lgl;
        br  = opc == BEQ || opc == BNE;
        ls  = opc == LW || opc == SW;
        lgl = opc inside {R, LW, SW, ADDI, ANDI, BEQ, BNE, J};
        for (int k = 0; k < fw; k++) begin
            e = '0; e.req = 1; e.b = 2'b01; e.err = k == MAX - 1;
            push(1, opc, z, 0, e, {nm, "/fetch_wait"});
            if (k == MAX - 1) return;
        end
        e = '0; e.req = 1; e.b = 2'b01; e.irw = 1; e.pcw = 1;
        push(1, opc, z, 1, e, {nm, "/fetch"});
        e = '0; e.st = 3'd1; e.b = 2'b11;
        if (opc == J) begin e.pcw = 1; e.pcs = 2'b10; end
        else if (!lgl) e.ill = 1;
        push(1, opc, z, 1, e, {nm, "/decode"});
        if (opc == J || !lgl) return;
        e = '0; e.st = 3'd2; e.a = 1;
        if (br) begin e.op = 2'b01; e.pcs = 2'b01; e.pcw = (opc == BEQ) ? z : !z; end
        else if (opc == R) e.op = 2'b10;
        else begin e.b = 2'b10; e.op = (opc == ANDI) ? 2'b11 : 2'b00; end
        push(1, opc, z, 1, e, {nm, "/exec"});
        if (br) return;
        if (ls) begin
            for (int k = 0; k < mw; k++) begin
                e = '0; e.st = 3'd3; e.req = 1; e.iord = 1; e.we = opc == SW; e.err = k == MAX - 1;
                push(1, opc, z, 0, e, {nm, "/mem_wait"});
                if (k == MAX - 1) return;
            end
            e = '0; e.st = 3'd3; e.req = 1; e.iord = 1; e.we = opc == SW;
            push(1, opc, z, 1, e, {nm, "/mem"});
            if (opc == SW) return;
        end
        e = '0; e.st = 3'd4; e.rw = 1; e.rd = opc == R; e.m2r = opc == LW;
        push(1, opc, z, 1, e, {nm, "/wb"});
    endtask

    task automatic pin_len(input int n0, input int want, input string nm);
        total++;
        if (q.size() - n0 != want) begin
            bad++;
            $display("FAIL len_%s: model cycles=%0d expected=%0d", nm, q.size() - n0, want);
        end
    endtask

    task automatic pin_last(input out_t want, input string nm);
        total++;
        if (q[q.size() - 1].e !== want) begin
            bad++;
            $display("FAIL pin_%s: model=%h expected=%h", nm, q[q.size() - 1].e, want);
        end
    endtask

    task automatic check(input cyc_t c);
        out_t g;
        g.st = state; g.req = bus.mem_req; g.we = bus.mem_we; g.iord = bus.iord;
        g.irw = ir_write; g.pcw = pc_write; g.pcs = pc_src; g.a = alusrc_a; g.b = alusrc_b;
        g.op = aluop; g.rd = regdst; g.m2r = memtoreg; g.rw = regwrite; g.ill = illegal;
        g.err = mem_err;
        total++;
        if (g !== c.e) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", c.tag, g, c.e);
        end
    endtask

    initial begin
        int   n0;
        cyc_t c;
        bus.mem_ready = 1'b0;
        push(0, R, 0, 1, '0, "reset");
        push(0, R, 0, 1, '0, "reset");
        n0 = q.size(); instr(R, 0, 0, 0, "rtype");
        pin_len(n0, 4, "rtype");
        pin_last('{st: 3'd4, rd: 1'b1, rw: 1'b1, default: '0}, "rtype_wb");
        n0 = q.size(); instr(LW, 0, 0, 3, "lw_wait");
        pin_len(n0, 8, "lw_wait");
        n0 = q.size(); instr(BEQ, 1, 0, 0, "beq_z1");
        pin_len(n0, 3, "beq");
        pin_last('{st: 3'd2, pcw: 1'b1, pcs: 2'b01, a: 1'b1, op: 2'b01, default: '0}, "beq_exec");
        instr(BEQ, 0, 0, 0, "beq_z0");
        instr(BNE, 1, 0, 0, "bne_z1");
        instr(BNE, 0, 0, 0, "bne_z0");
        n0 = q.size(); instr(J, 0, 0, 0, "j");
        pin_len(n0, 2, "j");
        n0 = q.size(); instr(6'b111111, 0, 0, 0, "illegal");
        pin_len(n0, 2, "illegal");
        instr(ADDI, 0, 0, 0, "addi");
        instr(ANDI, 0, 0, 0, "andi");
        n0 = q.size(); instr(SW, 0, 0, 0, "sw");
        pin_len(n0, 4, "sw");
        n0 = q.size(); instr(LW, 0, 0, 0, "lw");
        pin_len(n0, 5, "lw");
        instr(SW, 0, 3, 2, "sw_waits");
        instr(ADDI, 0, MAX - 1, 0, "ready_wins");
        n0 = q.size(); instr(R, 0, MAX, 0, "fetch_tmo");
        pin_len(n0, MAX, "fetch_tmo");
        instr(R, 0, 0, 0, "refetch");
        instr(LW, 0, 0, MAX, "mem_tmo");
        instr(SW, 0, 0, 0, "after_mem_tmo");
        n0 = q.size(); instr(LW, 0, 0, MAX, "rst_mid");
        q = q[0:n0 + 3];
        push(0, LW, 0, 0, '0, "rst_in_mem");
        push(0, LW, 0, 0, '0, "rst_held");
        instr(R, 0, 0, 0, "post_rst");

        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.rst; opcode = c.opc; zero = c.z; bus.mem_ready = c.rdy;
            @(negedge clk);
            check(c);
            @(posedge clk);
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
